// File: rtl/alu_op_sequencer_pkg.sv
// Shared state encoding, opcode constants and registered control-word layout
// for the ALU operation sequencer.
package alu_op_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StYLoad = 3'd1,
        StExec  = 3'd2,
        StWbLo  = 3'd3,
        StWbHi  = 3'd4
    } state_e;

    localparam logic [4:0] OpNop = 5'b00000;
    localparam logic [4:0] OpRol = 5'b00110;
    localparam logic [4:0] OpMul = 5'b01111;
    localparam logic [4:0] OpDiv = 5'b10000;
    localparam logic [4:0] OpNeg = 5'b10001;
    localparam logic [4:0] OpNot = 5'b10010;

    // Registered control word driven to the data path; all-zero is the reset value.
    typedef struct packed {
        logic        busy;
        logic        done;
        logic [15:0] rout;
        logic [15:0] rin;
        logic        yin;
        logic        zlowin;
        logic        zhighin;
        logic        zlowout;
        logic        zhighout;
        logic        loin;
        logic        hiin;
        logic [4:0]  op;
    } ctrl_t;

    function automatic logic is_unary(input logic [4:0] opc);
        return (opc == OpNeg) || (opc == OpNot);
    endfunction

    function automatic logic is_long(input logic [4:0] opc);
        return (opc == OpMul) || (opc == OpDiv);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request and data-path control bundle between the sequencer and its requester.
interface alu_op_sequencer_if;
    logic        start;
    logic [4:0]  opcode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic        busy;
    logic        done;
    logic [15:0] Rout;
    logic [15:0] Rin;
    logic        Yin;
    logic        Zlowin;
    logic        Zhighin;
    logic        Zlowout;
    logic        Zhighout;
    logic        LOin;
    logic        HIin;
    logic [4:0]  op;

    modport master (
        output start, opcode, ra, rb, rc,
        input  busy, done, Rout, Rin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin, op
    );

    modport slave (
        input  start, opcode, ra, rb, rc,
        output busy, done, Rout, Rin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin, op
    );
endinterface

// File: rtl/alu_op_sequencer_reg_decoder_4to16.sv
// 4-bit register index plus enable to a one-hot 16-bit enable vector.
module reg_decoder_4to16 (
    input  logic [3:0]  idx_i,
    input  logic        en_i,
    output logic [15:0] onehot_o
);
    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation over a shared bus: Y load, execute into Z,
// then write-back of Z low (and Z high for MUL/DIV) with fully registered controls.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
(
    input logic              Clock,
    input logic              clear,
    alu_op_sequencer_if.slave ctrl
);
    state_e      state_q, state_d;
    logic [4:0]  opcode_q, opcode_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [3:0]  rc_q, rc_d;
    ctrl_t       out_q, out_d;

    logic        rout_en;
    logic [3:0]  rout_idx;
    logic        rin_en;
    logic [15:0] rout_dec;
    logic [15:0] rin_dec;

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rc_d     = rc_q;
        unique case (state_q)
            StIdle: begin
                if (ctrl.start) begin
                    opcode_d = ctrl.opcode;
                    ra_d     = ctrl.ra;
                    rb_d     = ctrl.rb;
                    rc_d     = ctrl.rc;
                    state_d  = StYLoad;
                end
            end
            StYLoad: state_d = StExec;
            StExec:  state_d = StWbLo;
            StWbLo:  state_d = is_long(opcode_q) ? StWbHi : StIdle;
            StWbHi:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        rout_en  = (state_d == StYLoad) || ((state_d == StExec) && !is_unary(opcode_d));
        rout_idx = (state_d == StYLoad) ? rb_d : rc_d;
        rin_en   = (state_d == StWbLo) && !is_long(opcode_d);
    end

    reg_decoder_4to16 u_rout_dec (
        .idx_i    (rout_idx),
        .en_i     (rout_en),
        .onehot_o (rout_dec)
    );

    reg_decoder_4to16 u_rin_dec (
        .idx_i    (ra_d),
        .en_i     (rin_en),
        .onehot_o (rin_dec)
    );

    always_comb begin
        out_d          = '0;
        out_d.busy     = (state_d != StIdle);
        out_d.done     = rin_en || (state_d == StWbHi);
        out_d.rout     = rout_dec;
        out_d.rin      = rin_dec;
        out_d.yin      = (state_d == StYLoad);
        out_d.zlowin   = (state_d == StExec);
        out_d.zhighin  = (state_d == StExec);
        out_d.zlowout  = (state_d == StWbLo);
        out_d.zhighout = (state_d == StWbHi);
        out_d.loin     = (state_d == StWbLo) && is_long(opcode_d);
        out_d.hiin     = (state_d == StWbHi);
        out_d.op       = opcode_d;
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            state_q  <= StIdle;
            opcode_q <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rc_q     <= rc_d;
            out_q    <= out_d;
        end
    end

    assign ctrl.busy     = out_q.busy;
    assign ctrl.done     = out_q.done;
    assign ctrl.Rout     = out_q.rout;
    assign ctrl.Rin      = out_q.rin;
    assign ctrl.Yin      = out_q.yin;
    assign ctrl.Zlowin   = out_q.zlowin;
    assign ctrl.Zhighin  = out_q.zhighin;
    assign ctrl.Zlowout  = out_q.zlowout;
    assign ctrl.Zhighout = out_q.zhighout;
    assign ctrl.LOin     = out_q.loin;
    assign ctrl.HIin     = out_q.hiin;
    assign ctrl.op       = out_q.op;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: drives the sequencer against a small register-file/ALU model
// and checks control outputs cycle by cycle plus resulting register contents.
module tb_alu_op_sequencer;
    logic        clk;
    logic        clear;
    int unsigned n_vec;
    int unsigned n_err;

    alu_op_sequencer_if ctrl ();

    alu_op_sequencer u_dut (
        .Clock (clk),
        .clear (clear),
        .ctrl  (ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data-path model: register file, Y, 64-bit Z, LO, HI on a shared 32-bit bus.
    logic [31:0] rf [16];
    logic [31:0] y_r, lo_r, hi_r;
    logic [63:0] z_r;
    logic [31:0] bus;
    logic        mdl_rst;
    logic        pl_en;
    logic [3:0]  pl_idx;
    logic [31:0] pl_val;

    always_comb begin
        bus = '0;
        if (ctrl.Zlowout)  bus = bus | z_r[31:0];
        if (ctrl.Zhighout) bus = bus | z_r[63:32];
        for (int i = 0; i < 16; i++) begin
            if (ctrl.Rout[i]) bus = bus | rf[i];
        end
    end

    function automatic logic [63:0] alu(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
        logic [63:0] dbl;
        case (op)
            5'b00110: begin
                dbl = {a, a} << b[4:0];
                return {32'd0, dbl[63:32]};
            end
            5'b01111: return {32'd0, a} * {32'd0, b};
            5'b10000: return (b == 0) ? 64'd0 : {a % b, a / b};
            5'b10001: return {32'd0, -a};
            5'b10010: return {32'd0, ~a};
            default:  return {32'd0, a + b};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mdl_rst) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
            y_r <= '0; z_r <= '0; lo_r <= '0; hi_r <= '0;
        end else begin
            if (pl_en) rf[pl_idx] <= pl_val;
            if (ctrl.Yin) y_r <= bus;
            if (ctrl.Zlowin) z_r <= alu(ctrl.op, y_r, bus);
            for (int i = 0; i < 16; i++) begin
                if (ctrl.Rin[i]) rf[i] <= bus;
            end
            if (ctrl.LOin) lo_r <= bus;
            if (ctrl.HIin) hi_r <= bus;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        pl_en = 1'b1; pl_idx = idx; pl_val = val;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [4:0] opc, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c);
        ctrl.start = 1'b1; ctrl.opcode = opc; ctrl.ra = a; ctrl.rb = b; ctrl.rc = c;
        tick();
        ctrl.start = 1'b0;
    endtask

    // Every output packed; 46 bits, zero when idle after clear.
    function automatic logic [63:0] all_outs();
        return {18'd0, ctrl.busy, ctrl.done, ctrl.Rout, ctrl.Rin, ctrl.Yin, ctrl.Zlowin,
                ctrl.Zhighin, ctrl.Zlowout, ctrl.Zhighout, ctrl.LOin, ctrl.HIin, ctrl.op};
    endfunction

    // Bus-exclusivity invariants sampled every cycle once out of reset.
    logic mon_en;
    always @(negedge clk) begin
        if (mon_en) begin
            check("rout_onehot", 64'($countones(ctrl.Rout) <= 1), 64'd1);
            check("rin_onehot", 64'($countones(ctrl.Rin) <= 1), 64'd1);
            check("rout_rin_excl", 64'((ctrl.Rout != 0) && (ctrl.Rin != 0)), 64'd0);
            check("one_bus_driver",
                  64'(($countones(ctrl.Rout) + ctrl.Zlowout + ctrl.Zhighout) <= 1), 64'd1);
        end
    end

    int done_cnt;

    initial begin
        n_vec = 0; n_err = 0; mon_en = 1'b0;
        clear = 1'b1; mdl_rst = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_val = '0;
        ctrl.start = 1'b0; ctrl.opcode = 5'b00110; ctrl.ra = 4'd1; ctrl.rb = 4'd2; ctrl.rc = 4'd3;
        tick();
        ctrl.start = 1'b1;  // clear must dominate start
        tick();
        check("reset_outs", all_outs(), 64'd0);
        ctrl.start = 1'b0; clear = 1'b0; mdl_rst = 1'b0; mon_en = 1'b1;
        tick();
        check("idle_outs", all_outs(), 64'd0);

        // Binary ROL: R1 = rol(R3=12, R2=5)
        preload(4'd3, 32'd12);
        preload(4'd2, 32'd5);
        issue(5'b00110, 4'd1, 4'd3, 4'd2);
        check("rol_yload_rout", ctrl.Rout, 64'h0008);
        check("rol_yload_yin", ctrl.Yin, 64'd1);
        check("rol_yload_busy", ctrl.busy, 64'd1);
        check("rol_yload_op", ctrl.op, 64'h06);
        tick();
        check("rol_exec_rout", ctrl.Rout, 64'h0004);
        check("rol_exec_z", {ctrl.Yin, ctrl.Zlowin, ctrl.Zhighin}, 64'b011);
        check("rol_exec_op", ctrl.op, 64'h06);
        tick();
        check("rol_wblo_ctl", {ctrl.Zlowout, ctrl.done, ctrl.LOin}, 64'b110);
        check("rol_wblo_rin", ctrl.Rin, 64'h0002);
        check("rol_wblo_op", ctrl.op, 64'h06);
        tick();
        check("rol_idle", {ctrl.busy, ctrl.done}, 64'd0);
        check("rol_r1", rf[1], 64'd384);

        // MUL: LO:HI = R6*R7 = 3*9
        preload(4'd6, 32'd3);
        preload(4'd7, 32'd9);
        issue(5'b01111, 4'd4, 4'd6, 4'd7);
        check("mul_yload_rout", ctrl.Rout, 64'h0040);
        tick();
        check("mul_exec_rout", ctrl.Rout, 64'h0080);
        check("mul_exec_op", ctrl.op, 64'h0F);
        tick();
        check("mul_wblo", {ctrl.Zlowout, ctrl.LOin, ctrl.done, ctrl.busy}, 64'b1101);
        check("mul_wblo_rin", ctrl.Rin, 64'h0000);
        tick();
        check("mul_wbhi", {ctrl.Zhighout, ctrl.HIin, ctrl.done, ctrl.LOin}, 64'b1110);
        tick();
        check("mul_idle_busy", ctrl.busy, 64'd0);
        check("mul_lo", lo_r, 64'd27);
        check("mul_hi", hi_r, 64'd0);
        check("mul_r4", rf[4], 64'd0);

        // Unary NOT: R8 = ~R5
        preload(4'd5, 32'h0000FFFF);
        issue(5'b10010, 4'd8, 4'd5, 4'd9);
        check("not_yload_rout", ctrl.Rout, 64'h0020);
        tick();
        check("not_exec_rout", ctrl.Rout, 64'h0000);
        check("not_exec_z", {ctrl.Zlowin, ctrl.Zhighin}, 64'b11);
        tick();
        check("not_wblo_rin", ctrl.Rin, 64'h0100);
        check("not_wblo_done", ctrl.done, 64'd1);
        tick();
        check("not_r8", rf[8], 64'hFFFF0000);

        // Unlisted opcode (generic add) with start pulsed during EXEC: R10 = R1 + R2
        issue(5'b00011, 4'd10, 4'd1, 4'd2);
        tick();
        check("ign_exec_rout", ctrl.Rout, 64'h0004);
        ctrl.start = 1'b1; ctrl.opcode = 5'b01111; ctrl.ra = 4'd14;
        tick();
        ctrl.start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (ctrl.done) done_cnt++;
            tick();
        end
        check("ign_done_count", done_cnt, 64'd1);
        check("ign_busy_end", ctrl.busy, 64'd0);
        check("ign_r10", rf[10], 64'd389);
        check("ign_r14", rf[14], 64'd0);

        // clear at the edge entering WB_LO of an add into R11
        issue(5'b00011, 4'd11, 4'd3, 4'd2);
        check("clr_yload_rin", ctrl.Rin, 64'd0);
        tick();
        check("clr_exec_rin", ctrl.Rin, 64'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_outs", all_outs(), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clr_after", {ctrl.Rin, ctrl.done, ctrl.busy}, 64'd0);
        end
        check("clr_r11", rf[11], 64'd0);

        // Back-to-back: add into R12, then NEG into R13 from the idle cycle after done
        issue(5'b00011, 4'd12, 4'd3, 4'd2);
        tick();
        tick();
        check("b2b_first_done", ctrl.done, 64'd1);
        tick();
        check("b2b_idle_gap", ctrl.busy, 64'd0);
        issue(5'b10001, 4'd13, 4'd2, 4'd7);
        check("b2b_second_rout", ctrl.Rout, 64'h0004);
        tick();
        check("b2b_second_exec", {ctrl.Rout, ctrl.op}, {16'h0000, 5'b10001});
        tick();
        check("b2b_second_done", {ctrl.done, ctrl.Rin}, {1'b1, 16'h2000});
        tick();
        check("b2b_r12", rf[12], 64'd17);
        check("b2b_r13", rf[13], 64'hFFFFFFFB);
        tick();
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
